// File: rtl/bk_bus_pkg.sv
// Shared types, default interrupt vectors, parameter limits and data-lane
// helpers for the BK bus controller.
package bk_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STROBE,
        ST_REPLY,
        ST_ERROR,
        ST_IACK
    } bus_state_t;

    localparam logic [8:0] VEC_DEFAULT0 = 9'o060;
    localparam logic [8:0] VEC_DEFAULT1 = 9'o274;

    localparam int NCH_MIN      = 1;
    localparam int NCH_MAX      = 8;
    localparam int WAIT_CYC_MAX = 15;
    localparam int TIMEOUT_MIN  = 2;
    localparam int TIMEOUT_MAX  = 255;

    // An odd byte write replicates the low byte so the slave sees it on the high lane.
    function automatic logic [15:0] write_lane(input logic [15:0] dato,
                                               input logic        is_byte,
                                               input logic        odd);
        return (is_byte && odd) ? {dato[7:0], dato[7:0]} : dato;
    endfunction

    function automatic logic [15:0] read_lane(input logic [15:0] rdata,
                                              input logic        is_byte,
                                              input logic        odd);
        if (!is_byte)
            return rdata;
        else if (odd)
            return {8'h00, rdata[15:8]};
        else
            return {8'h00, rdata[7:0]};
    endfunction

endpackage

// File: rtl/bk_irq_prio.sv
// Fixed-priority interrupt encoder: channel 0 wins, and its 9-bit vector is
// selected along with a one-hot grant.
module bk_irq_prio
    import bk_bus_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]   req,
    input  logic [9*NCH-1:0] vec,
    output logic             any,
    output logic [NCH-1:0]   grant,
    output logic [8:0]       vector
);

    always_comb begin
        any    = 1'b0;
        grant  = '0;
        vector = '0;
        for (int i = 0; i < NCH; i++) begin
            if (req[i] && !any) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                vector   = vec[9*i +: 9];
            end
        end
    end

endmodule

// File: rtl/bk_bus_ctrl.sv
// BK CPU bus controller: bridges CPU SYNC/DIN/DOUT cycles to a simple slave
// strobe bus and services vectored interrupt acknowledge cycles.
module bk_bus_ctrl
    import bk_bus_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int WAIT_CYC = 0,
    parameter int TIMEOUT  = 32,
    parameter int IRQ_PRI  = 4
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             ce,
    input  logic             cpu_sync,
    input  logic             cpu_din,
    input  logic             cpu_dout,
    input  logic             cpu_wtbt,
    input  logic             cpu_iako,
    input  logic [15:0]      cpu_addr,
    input  logic [15:0]      cpu_dato,
    output logic [15:0]      cpu_dati,
    output logic             cpu_rply,
    output logic             cpu_error,
    output logic             cpu_virq,
    input  logic [2:0]       psw_pri,
    output logic             bus_rd,
    output logic             bus_wt,
    output logic             bus_byte,
    output logic [15:0]      bus_adr,
    output logic [15:0]      bus_wdata,
    input  logic [15:0]      bus_rdata,
    input  logic             bus_rdy,
    input  logic             bus_nxm,
    input  logic [NCH-1:0]   irq_req,
    input  logic [9*NCH-1:0] irq_vec,
    output logic [NCH-1:0]   irq_clr
);

    bus_state_t  state, state_next;
    logic        sync_q;
    logic        write_q;
    logic        byte_q;
    logic [15:0] addr_q;
    logic [3:0]  wait_cnt;
    logic [7:0]  tmo_cnt;
    logic        irq_any;
    logic [NCH-1:0] irq_grant;
    logic [8:0]  irq_vector;
    logic        sync_rise;
    logic        strobing;

    bk_irq_prio #(.NCH(NCH)) u_prio (
        .req    (irq_req),
        .vec    (irq_vec),
        .any    (irq_any),
        .grant  (irq_grant),
        .vector (irq_vector)
    );

    assign sync_rise = cpu_sync && !sync_q;
    assign strobing  = (state == ST_STROBE) && cpu_sync;
    assign cpu_virq  = (irq_req != '0) && (32'(psw_pri) < IRQ_PRI);

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset)
            state <= ST_IDLE;
        else if (ce)
            state <= state_next;
    end

    // Dropping SYNC in WAIT or STROBE abandons the cycle with no reply.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:
                if (sync_rise)
                    state_next = cpu_iako ? ST_IACK : ST_WAIT;
            ST_WAIT:
                if (!cpu_sync)
                    state_next = ST_IDLE;
                else if (wait_cnt == 4'(WAIT_CYC))
                    state_next = ST_STROBE;
            ST_STROBE:
                if (!cpu_sync)
                    state_next = ST_IDLE;
                else if (bus_nxm)
                    state_next = ST_ERROR;
                else if (bus_rdy)
                    state_next = ST_REPLY;
                else if (tmo_cnt == 8'(TIMEOUT - 1))
                    state_next = ST_ERROR;
            ST_REPLY, ST_ERROR:
                if (!cpu_sync)
                    state_next = ST_IDLE;
            ST_IACK:
                state_next = irq_any ? ST_REPLY : ST_ERROR;
            default:
                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_rply  = (state == ST_REPLY);
        cpu_error = (state == ST_ERROR);
        bus_rd    = strobing && !write_q;
        bus_wt    = strobing && write_q;
        bus_byte  = strobing && byte_q;
        bus_adr   = addr_q;
        bus_wdata = (strobing && write_q) ? write_lane(cpu_dato, byte_q, addr_q[0]) : 16'h0000;
        irq_clr   = (state == ST_IACK) ? irq_grant : '0;
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            sync_q   <= 1'b0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            addr_q   <= 16'h0000;
            wait_cnt <= 4'd0;
            tmo_cnt  <= 8'd0;
            cpu_dati <= 16'h0000;
        end else if (ce) begin
            sync_q <= cpu_sync;
            // A DIN request takes precedence over DOUT when both are asserted.
            if (state == ST_IDLE && sync_rise) begin
                addr_q  <= cpu_addr;
                write_q <= cpu_dout && !cpu_din;
                byte_q  <= cpu_wtbt;
            end
            wait_cnt <= (state == ST_WAIT && state_next == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
            tmo_cnt  <= (state == ST_STROBE && state_next == ST_STROBE) ? tmo_cnt + 8'd1 : 8'd0;
            if (state == ST_STROBE && state_next == ST_REPLY && !write_q)
                cpu_dati <= read_lane(bus_rdata, byte_q, addr_q[0]);
            else if (state == ST_IACK && irq_any)
                cpu_dati <= {7'b0, irq_vector};
        end
    end

endmodule

// File: tb/tb_bk_bus_ctrl.sv
// Directed self-checking bench for bk_bus_ctrl (WAIT_CYC=2, TIMEOUT=32, NCH=2).
module tb_bk_bus_ctrl;
    import bk_bus_pkg::*;

    logic        m_clock;
    logic        p_reset;
    logic        ce;
    logic        cpu_sync, cpu_din, cpu_dout, cpu_wtbt, cpu_iako;
    logic [15:0] cpu_addr, cpu_dato;
    logic [15:0] cpu_dati;
    logic        cpu_rply, cpu_error, cpu_virq;
    logic [2:0]  psw_pri;
    logic        bus_rd, bus_wt, bus_byte;
    logic [15:0] bus_adr, bus_wdata, bus_rdata;
    logic        bus_rdy, bus_nxm;
    logic [1:0]  irq_req;
    logic [17:0] irq_vec;
    logic [1:0]  irq_clr;

    int compared   = 0;
    int mismatched = 0;

    bk_bus_ctrl #(.NCH(2), .WAIT_CYC(2), .TIMEOUT(32), .IRQ_PRI(4)) dut (
        .m_clock   (m_clock),
        .p_reset   (p_reset),
        .ce        (ce),
        .cpu_sync  (cpu_sync),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_wtbt  (cpu_wtbt),
        .cpu_iako  (cpu_iako),
        .cpu_addr  (cpu_addr),
        .cpu_dato  (cpu_dato),
        .cpu_dati  (cpu_dati),
        .cpu_rply  (cpu_rply),
        .cpu_error (cpu_error),
        .cpu_virq  (cpu_virq),
        .psw_pri   (psw_pri),
        .bus_rd    (bus_rd),
        .bus_wt    (bus_wt),
        .bus_byte  (bus_byte),
        .bus_adr   (bus_adr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rdy   (bus_rdy),
        .bus_nxm   (bus_nxm),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_clr   (irq_clr)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    task automatic tick(input int n);
        repeat (n) @(posedge m_clock);
        #1;
    endtask

    // One ce-qualified cycle followed by two frozen cycles.
    task automatic tick_slow(input int n);
        repeat (n) begin
            ce = 1'b1;
            tick(1);
            ce = 1'b0;
            tick(2);
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] addr, input logic is_write,
                                  input logic is_byte, input logic [15:0] dato);
        cpu_addr = addr;
        cpu_dout = is_write;
        cpu_din  = !is_write;
        cpu_wtbt = is_byte;
        cpu_dato = dato;
        cpu_sync = 1'b1;
    endtask

    task automatic end_cycle();
        cpu_sync = 1'b0;
        cpu_din  = 1'b0;
        cpu_dout = 1'b0;
        cpu_iako = 1'b0;
        bus_rdy  = 1'b0;
        bus_nxm  = 1'b0;
        tick(1);
    endtask

    initial begin
        p_reset = 1'b1; ce = 1'b1;
        cpu_sync = 0; cpu_din = 0; cpu_dout = 0; cpu_wtbt = 0; cpu_iako = 0;
        cpu_addr = 0; cpu_dato = 0; psw_pri = 0;
        bus_rdata = 0; bus_rdy = 0; bus_nxm = 0;
        irq_req = 0; irq_vec = {VEC_DEFAULT1, VEC_DEFAULT0};
        #1;
        check_output("reset_rply", cpu_rply, 0);
        check_output("reset_error", cpu_error, 0);
        check_output("reset_dati", cpu_dati, 0);
        check_output("reset_adr", bus_adr, 0);
        check_output("reset_irq_clr", irq_clr, 0);
        tick(2);
        p_reset = 1'b0;
        tick(1);

        // Word read with two wait states
        apply_stimulus(16'o001000, 1'b0, 1'b0, 16'h0000);
        bus_rdata = 16'h1234;
        tick(3);
        check_output("rd_wait_no_strobe", bus_rd, 0);
        tick(1);
        check_output("rd_strobe", bus_rd, 1);
        check_output("rd_adr", bus_adr, 16'o001000);
        check_output("rd_not_byte", bus_byte, 0);
        bus_rdy = 1'b1;
        tick(1);
        bus_rdy = 1'b0;
        check_output("rd_rply", cpu_rply, 1);
        check_output("rd_dati", cpu_dati, 16'h1234);
        check_output("rd_strobe_off", bus_rd, 0);
        tick(2);
        check_output("rd_rply_held", cpu_rply, 1);
        end_cycle();
        check_output("rd_rply_released", cpu_rply, 0);

        // Byte write to odd address
        apply_stimulus(16'o001001, 1'b1, 1'b1, 16'h00A5);
        tick(4);
        check_output("bw_wt", bus_wt, 1);
        check_output("bw_rd", bus_rd, 0);
        check_output("bw_wdata", bus_wdata, 16'hA5A5);
        check_output("bw_byte", bus_byte, 1);
        bus_rdy = 1'b1;
        tick(1);
        check_output("bw_rply", cpu_rply, 1);
        end_cycle();

        // Byte read from odd address
        apply_stimulus(16'o001001, 1'b0, 1'b1, 16'h0000);
        bus_rdata = 16'hBEEF;
        tick(4);
        bus_rdy = 1'b1;
        tick(1);
        check_output("br_odd_dati", cpu_dati, 16'h00BE);
        end_cycle();

        // Timeout: no bus_rdy for 32 strobe cycles
        apply_stimulus(16'o002000, 1'b0, 1'b0, 16'h0000);
        tick(4);
        tick(31);
        check_output("tmo_still_strobe", bus_rd, 1);
        check_output("tmo_no_error_yet", cpu_error, 0);
        tick(1);
        check_output("tmo_error", cpu_error, 1);
        check_output("tmo_no_rply", cpu_rply, 0);
        check_output("tmo_strobe_off", bus_rd, 0);
        end_cycle();
        check_output("tmo_error_released", cpu_error, 0);

        // bus_nxm wins over a simultaneous bus_rdy
        apply_stimulus(16'o177000, 1'b0, 1'b0, 16'h0000);
        bus_rdata = 16'h5555;
        tick(4);
        bus_rdy = 1'b1;
        bus_nxm = 1'b1;
        tick(1);
        check_output("nxm_error", cpu_error, 1);
        check_output("nxm_no_rply", cpu_rply, 0);
        check_output("nxm_dati_kept", cpu_dati, 16'h00BE);
        end_cycle();

        // Interrupt acknowledge, both channels pending
        irq_req = 2'b11;
        psw_pri = 3'd0;
        #1;
        check_output("virq_on", cpu_virq, 1);
        cpu_iako = 1'b1;
        cpu_din  = 1'b1;
        cpu_sync = 1'b1;
        tick(1);
        check_output("iack_clr0", irq_clr, 2'b01);
        tick(1);
        check_output("iack_clr_pulse_end", irq_clr, 2'b00);
        check_output("iack_vec0", cpu_dati, 16'o060);
        check_output("iack_rply", cpu_rply, 1);
        end_cycle();
        psw_pri = 3'd4;
        #1;
        check_output("virq_masked_pri4", cpu_virq, 0);
        psw_pri = 3'd3;
        #1;
        check_output("virq_pri3", cpu_virq, 1);

        // Only channel 1 pending
        irq_req = 2'b10;
        cpu_iako = 1'b1;
        cpu_sync = 1'b1;
        tick(1);
        check_output("iack_clr1", irq_clr, 2'b10);
        tick(1);
        check_output("iack_vec1", cpu_dati, 16'o274);
        end_cycle();

        // IACK with nothing pending
        irq_req = 2'b00;
        #1;
        check_output("virq_none", cpu_virq, 0);
        cpu_iako = 1'b1;
        cpu_sync = 1'b1;
        tick(1);
        check_output("iack_empty_no_clr", irq_clr, 2'b00);
        tick(1);
        check_output("iack_empty_error", cpu_error, 1);
        check_output("iack_empty_no_rply", cpu_rply, 0);
        end_cycle();

        // Asynchronous reset in the middle of a write strobe
        apply_stimulus(16'o003000, 1'b1, 1'b0, 16'h1111);
        tick(4);
        check_output("rst_pre_wt", bus_wt, 1);
        p_reset = 1'b1;
        #1;
        check_output("rst_wt", bus_wt, 0);
        check_output("rst_adr", bus_adr, 0);
        check_output("rst_wdata", bus_wdata, 0);
        check_output("rst_dati", cpu_dati, 0);
        check_output("rst_rply", cpu_rply, 0);
        cpu_sync = 1'b0;
        cpu_dout = 1'b0;
        tick(1);
        p_reset = 1'b0;
        tick(1);

        // SYNC dropped during WAIT aborts without a strobe
        apply_stimulus(16'o004000, 1'b0, 1'b0, 16'h0000);
        tick(2);
        cpu_sync = 1'b0;
        #1;
        check_output("abort_no_rd", bus_rd, 0);
        tick(4);
        check_output("abort_still_no_rd", bus_rd, 0);
        check_output("abort_no_rply", cpu_rply, 0);
        end_cycle();

        // ce active one clock in three: timings stretch by three
        ce = 1'b0;
        tick(1);
        apply_stimulus(16'o005000, 1'b0, 1'b0, 16'h0000);
        bus_rdata = 16'hCAFE;
        tick_slow(3);
        check_output("slow_wait_no_rd", bus_rd, 0);
        tick_slow(1);
        check_output("slow_strobe_rd", bus_rd, 1);
        bus_rdy = 1'b1;
        tick_slow(1);
        check_output("slow_rply", cpu_rply, 1);
        check_output("slow_dati", cpu_dati, 16'hCAFE);
        cpu_sync = 1'b0;
        bus_rdy  = 1'b0;
        tick_slow(1);
        irq_req  = 2'b01;
        cpu_iako = 1'b1;
        cpu_sync = 1'b1;
        ce = 1'b1;
        tick(1);
        ce = 1'b0;
        check_output("slow_clr_on", irq_clr, 2'b01);
        tick(2);
        check_output("slow_clr_held", irq_clr, 2'b01);
        ce = 1'b1;
        tick(1);
        check_output("slow_clr_off", irq_clr, 2'b00);
        check_output("slow_iack_rply", cpu_rply, 1);
        end_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bk_bus_ctrl.md
BK_BUS_CTRL -- requirements
Module: bk_bus_ctrl

Interface
REQ-001 Parameter NCH, 2, number of vectored interrupt channels, legal range 1..8.
REQ-002 Parameter WAIT_CYC, 0, ce-qualified wait states inserted before slave strobe, range 0..15.
REQ-003 Parameter TIMEOUT, 32, ce-qualified cycles of strobe without bus_rdy before bus error, range 2..255.
REQ-004 Parameter IRQ_PRI, 4, interrupt allowed only while psw_pri < IRQ_PRI.
REQ-005 Reset is p_reset, asynchronous, active-high; clock is m_clock.
REQ-006 m_clock  in  1  system clock.
REQ-007 p_reset  in  1  asynchronous active-high reset.
REQ-008 ce  in  1  clock enable; all state advances only when ce=1.
REQ-009 cpu_sync, cpu_din, cpu_dout, cpu_wtbt, cpu_iako  in  1 each  CPU bus strobes; cpu_wtbt means byte access.
REQ-010 cpu_addr  in  16  CPU address; cpu_dato  in  16  CPU write data.
REQ-011 cpu_dati  out  16  read data or interrupt vector; cpu_rply  out  1  reply; cpu_error  out  1  bus error; cpu_virq  out  1  vectored interrupt request.
REQ-012 psw_pri  in  3  current CPU priority.
REQ-013 bus_rd, bus_wt, bus_byte  out  1 each; bus_adr  out  16; bus_wdata  out  16  slave-side access.
REQ-014 bus_rdata  in  16; bus_rdy  in  1  slave done; bus_nxm  in  1  nonexistent address.
REQ-015 irq_req  in  NCH  level requests; irq_vec  in  9*NCH  channel vectors, channel i in bits [9i+8:9i]; irq_clr  out  NCH  one-cycle acknowledge pulse.

Function
REQ-016 FSM states: IDLE, WAIT, STROBE, REPLY, ERROR, IACK.
REQ-017 IDLE: cpu_sync rising edge (registered sample) SHALL latch cpu_addr, direction (cpu_dout=write) and cpu_wtbt, then go to WAIT; with cpu_iako=1 go to IACK instead.
REQ-018 WAIT: count WAIT_CYC ce cycles, then STROBE; WAIT_CYC=0 enters STROBE on the next ce cycle.
REQ-019 STROBE: assert bus_rd or bus_wt with bus_adr = latched address; bus_rdy -> REPLY; bus_nxm or TIMEOUT elapsed -> ERROR; bus_nxm wins over simultaneous bus_rdy.
REQ-020 Write lane rule: byte write to odd address drives bus_wdata = {dato[7:0],dato[7:0]}; otherwise bus_wdata = cpu_dato.
REQ-021 Read lane rule: word -> bus_rdata; byte even -> {8'h00,rdata[7:0]}; byte odd -> {8'h00,rdata[15:8]}; captured into cpu_dati on the bus_rdy cycle.
REQ-022 REPLY: cpu_rply=1, bus strobes low, held until cpu_sync falls, then IDLE.
REQ-023 ERROR: cpu_error=1, cpu_rply=0, held until cpu_sync falls, then IDLE.
REQ-024 cpu_sync falling in WAIT or STROBE SHALL abort to IDLE in the same ce cycle with strobes dropped, no reply.
REQ-025 cpu_virq = (irq_req != 0) and (psw_pri < IRQ_PRI), combinational.
REQ-026 IACK: select lowest-index pending channel in the entry cycle, drive cpu_dati = {7'b0,irq_vec[ch]}, pulse irq_clr[ch] for exactly one ce cycle, then REPLY.
REQ-027 IACK with no request pending SHALL go to ERROR, no irq_clr pulse.
REQ-028 ce=0 freezes FSM, counters and outputs; irq_clr pulse width counts ce-qualified cycles.

Reset
REQ-029 p_reset SHALL force IDLE at any time, including mid-access, with cpu_rply, cpu_error, bus_rd, bus_wt, irq_clr, cpu_dati, bus_adr, bus_wdata, counters and sync sample all zero.

Structure
REQ-030 Package bk_bus_pkg SHALL hold FSM state enum, default vectors 'o060 and 'o274, and parameter range limits.
REQ-031 Sub-module bk_irq_prio SHALL implement the NCH-way fixed-priority encoder and vector mux.

Verification
REQ-032 Word read 'o001000, WAIT_CYC=2, bus_rdata=16'h1234 -> bus_rd after 2 ce cycles, cpu_dati=16'h1234, cpu_rply until SYNC falls.
REQ-033 Byte write 'o001001, dato=16'h00A5 -> bus_wdata=16'hA5A5, bus_byte=1; byte read odd with rdata=16'hBEEF -> cpu_dati=16'h00BE.
REQ-034 bus_rdy never asserted, TIMEOUT=32 -> cpu_error on 33rd ce cycle of STROBE, no cpu_rply; bus_nxm with bus_rdy same cycle -> ERROR.
REQ-035 irq_req=2'b11, vec0='o060, vec1='o274, psw_pri=0 -> virq=1, IACK returns 'o060, irq_clr=2'b01 one cycle; psw_pri=4 -> virq=0.
REQ-036 p_reset pulsed during STROBE -> all outputs 0 immediately; SYNC dropped in WAIT -> IDLE, no bus strobe; ce toggling 1-of-3 -> timings scale by 3.
